// File: rtl/ps2_scan_decoder_if.sv
// Byte-stream input and event-FIFO output bundle for the PS/2 scan decoder.
interface ps2_scan_decoder_if #(
    parameter int unsigned DEPTH = 8
);
    logic [7:0]               rx_data;
    logic                     read_data;
    logic                     pop;
    logic                     clr_ovf;
    logic [9:0]               dout;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output rx_data, read_data, pop, clr_ovf,
        input  dout, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, read_data, pop, clr_ovf,
        output dout, empty, full, count, overflow
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan decoder: strips E0/F0 prefixes and queues {release, extended, code} events.
module ps2_scan_decoder #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic               clk,
    input logic               reset,
    ps2_scan_decoder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state;
    state_t        next_on_byte;
    logic [TW-1:0] to_cnt;
    logic          read_data_q;
    logic          accept;
    logic          discard;
    logic          byte_ok;
    logic          is_e0;
    logic          is_f0;
    logic          push_req;
    logic [9:0]    push_data;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          overflow;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    always_comb begin
        accept = bus.read_data & ~read_data_q;
        unique case (bus.rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF: discard = 1'b1;
            default:                                  discard = 1'b0;
        endcase
        byte_ok = accept & ~discard;
        is_e0   = (bus.rx_data == 8'hE0);
        is_f0   = (bus.rx_data == 8'hF0);
    end

    // Decode the next state and any completed event for the byte on the bus this cycle.
    always_comb begin
        next_on_byte = state;
        push_req     = 1'b0;
        push_data    = {2'b00, bus.rx_data};
        unique case (state)
            IDLE: begin
                if (is_e0)      next_on_byte = EXT;
                else if (is_f0) next_on_byte = BRK;
                else            push_req     = byte_ok;
            end
            EXT: begin
                if (is_f0)       next_on_byte = EXT_BRK;
                else if (!is_e0) begin
                    push_req     = byte_ok;
                    push_data    = {2'b01, bus.rx_data};
                    next_on_byte = IDLE;
                end
            end
            BRK: begin
                if (is_e0)       next_on_byte = EXT_BRK;
                else if (!is_f0) begin
                    push_req     = byte_ok;
                    push_data    = {2'b10, bus.rx_data};
                    next_on_byte = IDLE;
                end
            end
            EXT_BRK: begin
                if (!is_e0 && !is_f0) begin
                    push_req     = byte_ok;
                    push_data    = {2'b11, bus.rx_data};
                    next_on_byte = IDLE;
                end
            end
            default: next_on_byte = IDLE;
        endcase
    end

    // Discarded bytes leave both state and timeout counter untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            read_data_q <= 1'b0;
        end else begin
            read_data_q <= bus.read_data;
            if (byte_ok) begin
                state  <= next_on_byte;
                to_cnt <= '0;
            end else if (!accept) begin
                if (state == IDLE) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_LAST) begin
                    state  <= IDLE;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

    always_comb begin
        do_pop  = bus.pop && (cnt != '0);
        do_push = push_req && ((cnt != FULL_CNT) || do_pop);
        drop    = push_req && (cnt == FULL_CNT) && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (drop)             overflow <= 1'b1;
            else if (bus.clr_ovf) overflow <= 1'b0;
        end
    end

    assign bus.dout     = (cnt == '0) ? '0 : mem[rd_ptr];
    assign bus.empty    = (cnt == '0);
    assign bus.full     = (cnt == FULL_CNT);
    assign bus.count    = cnt;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder with DEPTH=8 and a shortened timeout of 16 cycles.
module tb_ps2_scan_decoder;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    ps2_scan_decoder_if #(.DEPTH(DEPTH)) bus ();

    ps2_scan_decoder #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_pop;
        logic [7:0] b;
        int         exp_count;
        logic [9:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int c, input logic [9:0] d, input logic ov);
        chk({name, ".count"}, 32'(bus.count), 32'(c));
        chk({name, ".dout"}, 32'(bus.dout), 32'(d));
        chk({name, ".empty"}, 32'(bus.empty), 32'(c == 0));
        chk({name, ".full"}, 32'(bus.full), 32'(c == DEPTH));
        chk({name, ".ovf"}, 32'(bus.overflow), 32'(ov));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data   = b;
        bus.read_data = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
    endtask

    task automatic do_pop();
        @(negedge clk);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic add(input logic p, input logic [7:0] b, input int c, input logic [9:0] d);
        vec_t v;
        v.do_pop = p; v.b = b; v.exp_count = c; v.exp_dout = d;
        vecs.push_back(v);
    endtask

    initial begin
        reset         = 1'b1;
        bus.rx_data   = 8'h00;
        bus.read_data = 1'b0;
        bus.pop       = 1'b0;
        bus.clr_ovf   = 1'b0;

        add(0, 8'h1C, 1, 10'h01C);  add(1, 8'h00, 0, 10'h000);
        add(0, 8'hF0, 0, 10'h000);  add(0, 8'h1C, 1, 10'h21C);
        add(0, 8'hE0, 1, 10'h21C);  add(0, 8'h75, 2, 10'h21C);
        add(0, 8'hE0, 2, 10'h21C);  add(0, 8'hF0, 2, 10'h21C);
        add(0, 8'h75, 3, 10'h21C);  add(1, 8'h00, 2, 10'h175);
        add(1, 8'h00, 1, 10'h375);  add(1, 8'h00, 0, 10'h000);
        add(1, 8'h00, 0, 10'h000);  add(0, 8'hFA, 0, 10'h000);
        add(0, 8'hF0, 0, 10'h000);  add(0, 8'hFA, 0, 10'h000);
        add(0, 8'h1C, 1, 10'h21C);  add(1, 8'h00, 0, 10'h000);
        add(0, 8'hE0, 0, 10'h000);  add(0, 8'hE0, 0, 10'h000);
        add(0, 8'h6B, 1, 10'h16B);  add(1, 8'h00, 0, 10'h000);
        add(0, 8'hE0, 0, 10'h000);  add(0, 8'hF0, 0, 10'h000);
        add(0, 8'hE0, 0, 10'h000);  add(0, 8'h6B, 1, 10'h36B);
        add(1, 8'h00, 0, 10'h000);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all("reset", 0, 10'h000, 1'b0);

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_pop) do_pop();
            else                send_byte(vecs[i].b);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_dout, 1'b0);
        end

        // Stretched strobe: one event only.
        @(negedge clk);
        bus.rx_data   = 8'h29;
        bus.read_data = 1'b1;
        repeat (5) @(negedge clk);
        bus.read_data = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("stretch", 1, 10'h029, 1'b0);
        do_pop();

        // Prefix abandoned after timeout.
        send_byte(8'hE0);
        repeat (20) @(negedge clk);
        send_byte(8'h1C);
        chk_all("timeout", 1, 10'h01C, 1'b0);
        do_pop();

        // Prefix still live well inside the timeout.
        send_byte(8'hE0);
        repeat (5) @(negedge clk);
        send_byte(8'h1C);
        chk_all("no_timeout", 1, 10'h11C, 1'b0);
        do_pop();

        // Push and pop together while empty.
        @(negedge clk);
        bus.rx_data   = 8'h33;
        bus.read_data = 1'b1;
        bus.pop       = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
        bus.pop       = 1'b0;
        chk_all("push_pop_empty", 1, 10'h033, 1'b0);
        do_pop();
        chk_all("after_pop", 0, 10'h000, 1'b0);

        // Fill past DEPTH.
        for (int unsigned i = 1; i <= 9; i++) send_byte(8'(i));
        chk_all("overflow", 8, 10'h001, 1'b1);
        repeat (3) @(negedge clk);
        chk_all("ovf_sticky", 8, 10'h001, 1'b1);

        @(negedge clk);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        chk_all("clr_ovf", 8, 10'h001, 1'b0);

        @(negedge clk);
        bus.rx_data   = 8'h0A;
        bus.read_data = 1'b1;
        bus.pop       = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
        bus.pop       = 1'b0;
        chk_all("push_pop_full", 8, 10'h002, 1'b0);

        @(negedge clk);
        bus.rx_data   = 8'h0B;
        bus.read_data = 1'b1;
        bus.clr_ovf   = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
        bus.clr_ovf   = 1'b0;
        chk_all("drop_beats_clr", 8, 10'h002, 1'b1);

        repeat (5) do_pop();
        chk_all("drain5", 3, 10'h007, 1'b1);
        send_byte(8'hF0);
        chk_all("in_brk", 3, 10'h007, 1'b1);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all("mid_reset", 0, 10'h000, 1'b0);
        send_byte(8'h1C);
        chk_all("post_reset", 1, 10'h01C, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
